// File: rtl/bit_pack.sv
// rtl/bit_pack.sv - MSB-first serial-to-parallel packer with flush and a 2-entry output FIFO
module bit_pack #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_din,
    input  logic         i_vld,
    input  logic         i_flush,
    input  logic         i_rdy,
    output logic [W-1:0] o_dout,
    output logic         o_vld,
    output logic         o_part,
    output logic         o_ovf
);

    localparam int CW = (W > 2) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  sr_q, sr_d;
    logic [W-1:0]  e0_q, e0_d, e1_q, e1_d;
    logic          p0_q, p0_d, p1_q, p1_d;
    logic [1:0]    fcnt_q, fcnt_d;
    logic          ovf_q, ovf_d;

    logic [CW-1:0] idx;
    logic [W-1:0]  word;
    logic          full_bit;
    logic          push;
    logic          push_part;
    logic          pop;

    // Bits are written straight into their final position, so unfilled LSBs stay zero.
    always_comb begin
        idx  = LAST - cnt_q;
        word = sr_q;
        if (i_vld) begin
            word[idx] = i_din;
        end
        full_bit  = i_vld && (cnt_q == LAST);
        push      = full_bit || (i_flush && (i_vld || (cnt_q != '0)));
        push_part = !full_bit;

        cnt_d = cnt_q;
        sr_d  = sr_q;
        if (push) begin
            cnt_d = '0;
            sr_d  = '0;
        end else if (i_vld) begin
            cnt_d = cnt_q + 1'b1;
            sr_d  = word;
        end
    end

    // Head is always entry 0; a pop shifts entry 1 forward before any push is placed.
    always_comb begin
        pop    = (fcnt_q != 2'd0) && i_rdy;
        e0_d   = e0_q;
        e1_d   = e1_q;
        p0_d   = p0_q;
        p1_d   = p1_q;
        fcnt_d = fcnt_q;
        ovf_d  = ovf_q;

        if (pop) begin
            e0_d   = e1_q;
            p0_d   = p1_q;
            e1_d   = '0;
            p1_d   = 1'b0;
            fcnt_d = fcnt_q - 2'd1;
        end

        if (push) begin
            case (fcnt_d)
                2'd0: begin
                    e0_d   = word;
                    p0_d   = push_part;
                    fcnt_d = 2'd1;
                end
                2'd1: begin
                    e1_d   = word;
                    p1_d   = push_part;
                    fcnt_d = 2'd2;
                end
                default: begin
                    ovf_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q  <= '0;
            sr_q   <= '0;
            e0_q   <= '0;
            e1_q   <= '0;
            p0_q   <= 1'b0;
            p1_q   <= 1'b0;
            fcnt_q <= 2'd0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sr_q   <= sr_d;
            e0_q   <= e0_d;
            e1_q   <= e1_d;
            p0_q   <= p0_d;
            p1_q   <= p1_d;
            fcnt_q <= fcnt_d;
            ovf_q  <= ovf_d;
        end
    end

    assign o_dout = e0_q;
    assign o_part = p0_q;
    assign o_vld  = (fcnt_q != 2'd0);
    assign o_ovf  = ovf_q;

endmodule

// File: tb/tb_bit_pack.sv
// tb/tb_bit_pack.sv - directed scoreboard bench for bit_pack at W=8
module tb_bit_pack;

    localparam int W = 8;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_din = 1'b0;
    logic         i_vld = 1'b0;
    logic         i_flush = 1'b0;
    logic         i_rdy = 1'b0;
    logic [W-1:0] o_dout;
    logic         o_vld;
    logic         o_part;
    logic         o_ovf;

    int checks = 0;
    int failures = 0;
    logic [W:0] exp_q[$];

    always #5 i_clk = ~i_clk;

    bit_pack #(.W(W)) dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_din  (i_din),
        .i_vld  (i_vld),
        .i_flush(i_flush),
        .i_rdy  (i_rdy),
        .o_dout (o_dout),
        .o_vld  (o_vld),
        .o_part (o_part),
        .o_ovf  (o_ovf)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle; a handshake seen before the edge is scored against the queue head.
    task automatic step(input logic rst, input logic din, input logic vld,
                        input logic flush, input logic rdy);
        logic [W:0] e;
        @(negedge i_clk);
        i_rst = rst; i_din = din; i_vld = vld; i_flush = flush; i_rdy = rdy;
        #1;
        if (!rst && o_vld && rdy) begin
            if (exp_q.size() == 0) begin
                chk("spurious_word", {o_part, o_dout}, 64'h0);
            end else begin
                e = exp_q.pop_front();
                chk("word", {o_part, o_dout}, e);
            end
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_word(input logic [7:0] w, input logic rdy_rest,
                             input logic rdy_last, input logic flush_last);
        for (int i = W - 1; i >= 0; i--) begin
            step(1'b0, w[i], 1'b1, (i == 0) ? flush_last : 1'b0,
                 (i == 0) ? rdy_last : rdy_rest);
        end
    endtask

    initial begin
        logic [7:0] b;

        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_vld", o_vld, 0);
        chk("rst_dout", o_dout, 0);
        chk("rst_part", o_part, 0);
        chk("rst_ovf", o_ovf, 0);

        exp_q.push_back({1'b0, 8'hB2});
        send_word(8'hB2, 1'b1, 1'b1, 1'b0);
        chk("b2_latency_vld", o_vld, 1);
        chk("b2_dout", o_dout, 8'hB2);
        chk("b2_part", o_part, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("e0_no_early_vld", o_vld, 0);
        exp_q.push_back({1'b1, 8'hE0});
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("e0_vld", o_vld, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("empty_flush_no_vld", o_vld, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("empty_flush_no_vld2", o_vld, 0);

        b = 8'hB2;
        for (int i = W - 1; i >= 0; i--) begin
            if (i == 0) exp_q.push_back({1'b0, 8'hB2});
            step(1'b0, b[i], 1'b1, 1'b0, 1'b1);
            if (i != 0) begin
                step(1'b0, ~b[i], 1'b0, 1'b0, 1'b1);
                chk("gap_no_early_vld", o_vld, 0);
            end
        end
        chk("gap_dout", o_dout, 8'hB2);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        exp_q.push_back({1'b0, 8'h0F});
        send_word(8'h0F, 1'b1, 1'b1, 1'b1);
        chk("flush_on_full_part", o_part, 0);
        exp_q.push_back({1'b1, 8'h80});
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("flush_one_bit_dout", o_dout, 8'h80);
        chk("flush_one_bit_part", o_part, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b0, 8'h22});
        send_word(8'h11, 1'b0, 1'b0, 1'b0);
        send_word(8'h22, 1'b0, 1'b0, 1'b0);
        chk("full_no_ovf_yet", o_ovf, 0);
        send_word(8'h33, 1'b0, 1'b0, 1'b0);
        chk("ovf_set", o_ovf, 1);
        chk("head_held", o_dout, 8'h11);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("head_held2", o_dout, 8'h11);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovf_drained", o_vld, 0);
        chk("ovf_sticky", o_ovf, 1);

        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("midrst_vld", o_vld, 0);
        chk("midrst_ovf", o_ovf, 0);
        exp_q.push_back({1'b0, 8'hFF});
        send_word(8'hFF, 1'b1, 1'b1, 1'b0);
        chk("ff_dout", o_dout, 8'hFF);
        chk("ff_part", o_part, 0);
        chk("ff_ovf", o_ovf, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        exp_q.push_back({1'b0, 8'hA5});
        exp_q.push_back({1'b0, 8'h3C});
        exp_q.push_back({1'b0, 8'hC3});
        send_word(8'hA5, 1'b0, 1'b0, 1'b0);
        send_word(8'h3C, 1'b0, 1'b0, 1'b0);
        send_word(8'hC3, 1'b0, 1'b1, 1'b0);
        chk("pushpop_head", o_dout, 8'h3C);
        chk("pushpop_no_ovf", o_ovf, 0);

        for (int n = 0; n < 6; n++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        chk("final_idle_vld", o_vld, 0);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("final_ovf", o_ovf, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bit_pack.md
BIT_PACK -- requirements
Module: bit_pack

Interface
REQ-001 SHALL have parameter W, default 16, meaning output word width in bits (legal range 2..64).
REQ-002 SHALL have port i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port i_rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port i_din  input  1  serial data bit from delay-line output.
REQ-005 SHALL have port i_vld  input  1  qualifies i_din; bit captured only when high.
REQ-006 SHALL have port i_flush  input  1  closes the current partial word.
REQ-007 SHALL have port i_rdy  input  1  downstream ready.
REQ-008 SHALL have port o_dout  output  W  packed word at FIFO head.
REQ-009 SHALL have port o_vld  output  1  o_dout valid.
REQ-010 SHALL have port o_part  output  1  head word was closed by flush with fewer than W bits.
REQ-011 SHALL have port o_ovf  output  1  sticky overflow flag.

Function
REQ-012 SHALL pack bits MSB-first: the first captured bit of a word lands in bit W-1, the k-th bit (k=0..W-1) in bit W-1-k.
REQ-013 SHALL keep a bit counter 0..W-1, incremented on each cycle with i_vld=1; cycles with i_vld=0 leave counter and shift register unchanged.
REQ-014 SHALL complete a full word on the cycle where i_vld=1 and counter=W-1; the word is pushed to the output FIFO at that edge, o_part=0, and the counter returns to 0.
REQ-015 SHALL, on i_flush=1 with counter>0 or i_vld=1, include the same-cycle i_vld bit (if any), zero-pad the remaining LSBs, push the word with o_part=1 (o_part=0 if exactly W bits resulted), and clear the counter.
REQ-016 SHALL ignore i_flush when counter=0 and i_vld=0 (no empty word pushed).
REQ-017 SHALL use a 2-entry output FIFO; o_vld=1 whenever it is non-empty; o_dout/o_part show the head entry; o_dout=0 and o_part=0 when empty.
REQ-018 SHALL pop the head on any edge where o_vld=1 and i_rdy=1.
REQ-019 SHALL have latency of one cycle: a word completed at edge N is visible on o_vld/o_dout after edge N when the FIFO was empty.
REQ-020 SHALL accept a push into a full FIFO if a pop occurs at the same edge (throughput of one word per cycle with i_rdy=1).
REQ-021 SHALL, when a word completes while the FIFO is full and no pop occurs, drop the new word, keep existing entries unchanged, and set o_ovf=1.
REQ-022 SHALL hold o_ovf=1 until reset; it does not affect further packing.
REQ-023 SHALL keep o_dout/o_part stable while o_vld=1 and i_rdy=0.
REQ-024 SHALL preserve word order: words leave in completion order.

Reset
REQ-025 SHALL, when i_rst=1 at an edge, clear counter, shift register, FIFO, and o_ovf, giving o_vld=0, o_dout=0, o_part=0, o_ovf=0 after that edge.
REQ-026 SHALL discard a partially packed word and all buffered words on reset, including mid-word; i_vld/i_flush/i_rdy are ignored on the reset cycle.

Verification
REQ-027 SHALL cover (W=8) bits 1,0,1,1,0,0,1,0 on 8 consecutive i_vld cycles, i_rdy=1 -> o_vld high one cycle after 8th bit, o_dout=8'hB2, o_part=0.
REQ-028 SHALL cover (W=8) bits 1,1,1 then i_flush alone -> o_dout=8'hE0, o_part=1; a second i_flush with no bits -> no o_vld.
REQ-029 SHALL cover (W=8) same bits as REQ-027 with i_vld low on alternating cycles -> o_dout=8'hB2 after 8th valid bit, no early o_vld.
REQ-030 SHALL cover (W=8) i_rdy=0, three full words 8'h11, 8'h22, 8'h33 -> head 8'h11 held, o_ovf=1 after third; raising i_rdy yields 8'h11 then 8'h22 only.
REQ-031 SHALL cover (W=8) 5 bits captured, i_rst pulsed, then 8 bits of 1 -> single word 8'hFF, o_part=0, o_ovf=0.
REQ-032 SHALL cover (W=8) full FIFO with i_rdy=1 and a word completing the same cycle -> no drop, o_ovf stays 0, order preserved.
